ll_seizure_detector: RTL and testbench



---
 rtl/ll_seizure_detector.sv | 164 ++++++++++++++++
 tb/tb_ll_seizure_detector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ll_seizure_detector.sv
// Windowed line-length accumulator with a debounced, hysteretic seizure alarm.
// Each completed window is compared to thr_hi/thr_lo and steps a four-state decision FSM.
module ll_seizure_detector #(
  parameter int DATA_WIDTH = 32,
  parameter int WIN_LEN    = 256,
  parameter int ON_COUNT   = 3,
  parameter int OFF_COUNT  = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DATA_WIDTH-1:0]                   din,
  input  logic                                    en,
  input  logic [DATA_WIDTH+$clog2(WIN_LEN)-1:0]   thr_hi,
  input  logic [DATA_WIDTH+$clog2(WIN_LEN)-1:0]   thr_lo,
  output logic [DATA_WIDTH+$clog2(WIN_LEN)-1:0]   win_sum,
  output logic                                    win_valid,
  output logic                                    alarm,
  output logic                                    alarm_rise,
  output logic                                    alarm_fall
);

  localparam int CW = $clog2(WIN_LEN);
  localparam int SW = DATA_WIDTH + CW;
  localparam logic [3:0] ON_C  = 4'(ON_COUNT);
  localparam logic [3:0] OFF_C = 4'(OFF_COUNT);

  typedef enum logic [1:0] {IDLE, PENDING, ALARM, RELEASING} state_t;

  state_t        state_q, state_d;
  logic [3:0]    run_q, run_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          valid_q, valid_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  logic [SW-1:0] din_clamped;
  logic [SW-1:0] sum_new;
  logic          window_done;
  logic          is_hi;
  logic          is_lo;

  // Negative line-length values are clamped to zero before accumulation.
  assign din_clamped = din[DATA_WIDTH-1] ? '0 : SW'(din);
  assign sum_new     = acc_q + din_clamped;
  assign window_done = en && (cnt_q == CW'(WIN_LEN - 1));
  assign is_hi       = sum_new > thr_hi;
  assign is_lo       = sum_new < thr_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (en) begin
      if (window_done) begin
        acc_d   = '0;
        cnt_d   = '0;
        sum_d   = sum_new;
        valid_d = 1'b1;
      end else begin
        acc_d = sum_new;
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Decision runs on the last sample's edge so alarm moves together with win_valid.
    if (window_done) begin
      case (state_q)
        IDLE: begin
          if (is_hi) begin
            if (ON_C == 4'd1) begin
              state_d = ALARM;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = PENDING;
              run_d   = 4'd1;
            end
          end
        end
        PENDING: begin
          if (is_hi) begin
            if (run_q + 4'd1 >= ON_C) begin
              state_d = ALARM;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
        ALARM: begin
          if (is_lo) begin
            if (OFF_C == 4'd1) begin
              state_d = IDLE;
              run_d   = '0;
              fall_d  = 1'b1;
            end else begin
              state_d = RELEASING;
              run_d   = 4'd1;
            end
          end
        end
        RELEASING: begin
          if (is_lo) begin
            if (run_q + 4'd1 >= OFF_C) begin
              state_d = IDLE;
              run_d   = '0;
              fall_d  = 1'b1;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            state_d = ALARM;
            run_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  assign win_sum    = sum_q;
  assign win_valid  = valid_q;
  assign alarm      = (state_q == ALARM) || (state_q == RELEASING);
  assign alarm_rise = rise_q;
  assign alarm_fall = fall_q;

endmodule

// File: tb/tb_ll_seizure_detector.sv
// Directed bench for ll_seizure_detector with WIN_LEN=4, ON_COUNT=2, OFF_COUNT=2.
// A window table drives the main FSM walk; hand sequences cover reset, gaps and max values.
module tb_ll_seizure_detector;

  localparam int DW = 32;
  localparam int SW = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          en;
  logic [SW-1:0] thr_hi;
  logic [SW-1:0] thr_lo;
  logic [SW-1:0] win_sum;
  logic          win_valid;
  logic          alarm;
  logic          alarm_rise;
  logic          alarm_fall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ll_seizure_detector #(
    .DATA_WIDTH(DW),
    .WIN_LEN   (4),
    .ON_COUNT  (2),
    .OFF_COUNT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .en        (en),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .win_sum   (win_sum),
    .win_valid (win_valid),
    .alarm     (alarm),
    .alarm_rise(alarm_rise),
    .alarm_fall(alarm_fall)
  );

  typedef struct {
    logic signed [DW-1:0] d0, d1, d2, d3;
    logic [SW-1:0]        sum;
    logic                 alarm;
    logic                 rise;
    logic                 fall;
  } win_vec_t;

  win_vec_t vec[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [DW-1:0] d);
    din = d;
    en  = 1'b1;
    tick();
    en  = 1'b0;
  endtask

  task automatic chk_all(input string name, input logic v, input logic [SW-1:0] s,
                         input logic a, input logic r, input logic f);
    chk({name, ".win_valid"}, 64'(win_valid), 64'(v));
    chk({name, ".win_sum"}, 64'(win_sum), 64'(s));
    chk({name, ".alarm"}, 64'(alarm), 64'(a));
    chk({name, ".alarm_rise"}, 64'(alarm_rise), 64'(r));
    chk({name, ".alarm_fall"}, 64'(alarm_fall), 64'(f));
  endtask

  initial begin
    logic [SW-1:0] last_sum;
    logic          last_alarm;

    rst = 1'b1; en = 1'b1; din = 32'd50;
    thr_hi = 34'd100; thr_lo = 34'd40;
    tick();
    tick();
    chk_all("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b0;

    // Window with gaps and a clamped negative sample.
    push(32'sd10); tick();
    push(32'sd20); tick(); tick();
    push(-32'sd5);
    chk("gap.mid_valid", 64'(win_valid), 64'd0);
    tick();
    push(32'sd30);
    chk_all("gap.window", 1'b1, 34'd60, 1'b0, 1'b0, 1'b0);
    tick();
    chk("gap.pulse_end", 64'(win_valid), 64'd0);
    $display("txn gap_window sum=%0d", win_sum);

    vec[0]  = '{30, 30, 30, 30, 34'd120, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{30, 30, 30, 30, 34'd120, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{10, 10,  5,  5, 34'd30,  1'b1, 1'b0, 1'b0};
    vec[3]  = '{20, -7, 20, 10, 34'd50,  1'b1, 1'b0, 1'b0};
    vec[4]  = '{10, 10,  5,  5, 34'd30,  1'b1, 1'b0, 1'b0};
    vec[5]  = '{10, 10,  5,  5, 34'd30,  1'b0, 1'b0, 1'b1};
    vec[6]  = '{30, 30, 30, 30, 34'd120, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{25, 25, 25, 25, 34'd100, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{30, 30, 30, 30, 34'd120, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{25, 25, 25, 25, 34'd100, 1'b0, 1'b0, 1'b0};
    vec[10] = '{30, 30, 30, 30, 34'd120, 1'b0, 1'b0, 1'b0};
    vec[11] = '{40, 40, 20, 20, 34'd120, 1'b1, 1'b1, 1'b0};
    vec[12] = '{10, 10,  5,  5, 34'd30,  1'b1, 1'b0, 1'b0};
    vec[13] = '{10, 10, 10, 10, 34'd40,  1'b1, 1'b0, 1'b0};
    vec[14] = '{10, 10,  5,  5, 34'd30,  1'b1, 1'b0, 1'b0};
    vec[15] = '{30, 30, 30, 30, 34'd120, 1'b1, 1'b0, 1'b0};

    for (int w = 0; w < 16; w++) begin
      push(vec[w].d0);
      push(vec[w].d1);
      push(vec[w].d2);
      push(vec[w].d3);
      chk_all($sformatf("win%0d", w), 1'b1, vec[w].sum, vec[w].alarm, vec[w].rise, vec[w].fall);
      tick();
      chk($sformatf("win%0d.pulse_end", w), 64'({win_valid, alarm_rise, alarm_fall}), 64'd0);
      chk($sformatf("win%0d.alarm_hold", w), 64'(alarm), 64'(vec[w].alarm));
      $display("txn win%0d sum=%0d alarm=%0d rise=%0d fall=%0d",
               w, win_sum, alarm, alarm_rise, alarm_fall);
    end

    // Reset while alarmed with a partial window pending.
    push(32'sd50);
    push(32'sd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_alarm", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_alarm.no_fall", 64'(alarm_fall), 64'd0);
    push(32'sd10); push(32'sd10); push(32'sd10); push(32'sd10);
    chk_all("rst_alarm.fresh", 1'b1, 34'd40, 1'b0, 1'b0, 1'b0);
    $display("txn rst_alarm_fresh sum=%0d", win_sum);
    tick();

    // Full-scale samples: no wrap in the wide accumulator.
    thr_hi = 34'h1_FFFF_FFF8;
    for (int k = 0; k < 4; k++) push(32'sh7FFF_FFFF);
    chk_all("max.win0", 1'b1, 34'h1_FFFF_FFFC, 1'b0, 1'b0, 1'b0);
    $display("txn max_win0 sum=%0d", win_sum);
    tick();
    for (int k = 0; k < 4; k++) push(32'sh7FFF_FFFF);
    chk_all("max.win1", 1'b1, 34'h1_FFFF_FFFC, 1'b1, 1'b1, 1'b0);
    $display("txn max_win1 sum=%0d alarm=%0d", win_sum, alarm);
    last_sum   = win_sum;
    last_alarm = alarm;
    tick();
    chk("max.hold_sum", 64'(win_sum), 64'h1_FFFF_FFFC);
    chk("max.hold_alarm", 64'(last_alarm), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
